// File: rtl/deskew_lane_buffer.sv
// Per-lane deskew stage: lane skew counter plus a delay line that holds this lane's
// 66b blocks back by (common_count - lane_count) valid beats once the delay is locked.
module deskew_lane_buffer #(
  parameter int NB_DATA  = 66,
  parameter int MAX_SKEW = 16,
  parameter int NB_COUNT = $clog2(MAX_SKEW) + 1
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_resync,
  input  logic                i_valid,
  input  logic [NB_DATA-1:0]  i_data,
  input  logic                i_enable_counter,
  input  logic                i_stop_counter,
  input  logic                i_set_fifo_delay,
  input  logic [NB_COUNT-1:0] i_common_counter,
  output logic                o_valid,
  output logic [NB_DATA-1:0]  o_data,
  output logic [NB_COUNT-1:0] o_lane_counter,
  output logic [NB_COUNT-1:0] o_delay,
  output logic                o_delay_valid,
  output logic [1:0]          o_dbg_state
);

  localparam int NB_PTR = $clog2(MAX_SKEW);
  localparam logic [NB_COUNT-1:0] SKEW_MAX  = NB_COUNT'(MAX_SKEW);
  localparam logic [NB_COUNT-1:0] DELAY_MAX = NB_COUNT'(MAX_SKEW - 1);
  localparam logic [NB_COUNT:0]   DEPTH_W   = (NB_COUNT + 1)'(MAX_SKEW);
  localparam logic [NB_PTR-1:0]   PTR_LAST  = NB_PTR'(MAX_SKEW - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_COUNT, ST_HOLD, ST_LOCKED} state_t;

  state_t              state_q, state_d;
  logic [NB_COUNT-1:0] counter_q, counter_d;
  logic [NB_COUNT-1:0] delay_q, delay_d;
  logic                delay_valid_q, delay_valid_d;
  logic [NB_PTR-1:0]   wr_ptr_q, wr_ptr_d;
  logic                valid_q, valid_d;
  logic [NB_DATA-1:0]  data_q, data_d;
  logic [NB_DATA-1:0]  mem_q [MAX_SKEW];

  logic                clr;
  logic                wr_en;
  logic [NB_COUNT-1:0] lock_diff;
  logic [NB_COUNT-1:0] lock_delay;
  logic [NB_COUNT:0]   rd_sum;
  logic [NB_COUNT:0]   rd_wrap;
  logic [NB_PTR-1:0]   rd_ptr;

  assign clr = i_reset | i_resync;

  // Delay to latch if a lock happens this cycle; the lane never waits on itself.
  always_comb begin
    lock_diff = '0;
    if (i_common_counter >= counter_q) lock_diff = i_common_counter - counter_q;
    lock_delay = (lock_diff > DELAY_MAX) ? DELAY_MAX : lock_diff;
  end

  always_comb begin
    state_d       = state_q;
    counter_d     = counter_q;
    delay_d       = delay_q;
    delay_valid_d = delay_valid_q;
    if (i_enable) begin
      case (state_q)
        ST_IDLE: begin
          counter_d = '0;
          // The enabling cycle is already the first skew beat.
          if (i_enable_counter) begin
            state_d = ST_COUNT;
            if (!i_stop_counter) counter_d = NB_COUNT'(1);
          end
        end
        ST_COUNT: begin
          if (i_set_fifo_delay) begin
            state_d       = ST_LOCKED;
            delay_d       = lock_delay;
            delay_valid_d = 1'b1;
          end else if (i_stop_counter) begin
            state_d = ST_HOLD;
          end else if (!i_enable_counter) begin
            state_d   = ST_IDLE;
            counter_d = '0;
          end else if (counter_q != SKEW_MAX) begin
            counter_d = counter_q + NB_COUNT'(1);
          end
        end
        ST_HOLD: begin
          if (i_set_fifo_delay) begin
            state_d       = ST_LOCKED;
            delay_d       = lock_delay;
            delay_valid_d = 1'b1;
          end else if (!i_enable_counter) begin
            state_d   = ST_IDLE;
            counter_d = '0;
          end
        end
        ST_LOCKED: state_d = ST_LOCKED;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Read slot sits delay_q entries behind the slot being written this beat.
  always_comb begin
    rd_sum  = {{(NB_COUNT + 1 - NB_PTR){1'b0}}, wr_ptr_q} + DEPTH_W - {1'b0, delay_q};
    rd_wrap = (rd_sum >= DEPTH_W) ? (rd_sum - DEPTH_W) : rd_sum;
    rd_ptr  = NB_PTR'(rd_wrap);
  end

  always_comb begin
    wr_en    = i_valid & ~clr;
    valid_d  = i_valid;
    wr_ptr_d = wr_ptr_q;
    data_d   = data_q;
    if (i_valid) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + NB_PTR'(1);
      data_d   = (delay_q == '0) ? i_data : mem_q[rd_ptr];
    end
  end

  always_ff @(posedge i_clock) begin
    if (clr) begin
      state_q       <= ST_IDLE;
      counter_q     <= '0;
      delay_q       <= '0;
      delay_valid_q <= 1'b0;
      wr_ptr_q      <= '0;
      valid_q       <= 1'b0;
      data_q        <= '0;
    end else begin
      state_q       <= state_d;
      counter_q     <= counter_d;
      delay_q       <= delay_d;
      delay_valid_q <= delay_valid_d;
      wr_ptr_q      <= wr_ptr_d;
      valid_q       <= valid_d;
      data_q        <= data_d;
    end
  end

  always_ff @(posedge i_clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_valid        = valid_q;
  assign o_data         = data_q;
  assign o_lane_counter = counter_q;
  assign o_delay        = delay_q;
  assign o_delay_valid  = delay_valid_q;
  assign o_dbg_state    = state_q;

endmodule

// File: tb/tb_deskew_lane_buffer.sv
// Bench for deskew_lane_buffer: vector table, directed corner sequences and a random
// run, all checked against a history-queue reference model.
module tb_deskew_lane_buffer;
  localparam int NB_DATA  = 66;
  localparam int MAX_SKEW = 16;
  localparam int NB_COUNT = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                i_reset, i_enable, i_resync, i_valid;
  logic [NB_DATA-1:0]  i_data;
  logic                i_enable_counter, i_stop_counter, i_set_fifo_delay;
  logic [NB_COUNT-1:0] i_common_counter;
  logic                o_valid, o_delay_valid;
  logic [NB_DATA-1:0]  o_data;
  logic [NB_COUNT-1:0] o_lane_counter, o_delay;
  logic [1:0]          o_dbg_state;

  deskew_lane_buffer #(.NB_DATA(NB_DATA), .MAX_SKEW(MAX_SKEW), .NB_COUNT(NB_COUNT)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_enable(i_enable), .i_resync(i_resync),
    .i_valid(i_valid), .i_data(i_data), .i_enable_counter(i_enable_counter),
    .i_stop_counter(i_stop_counter), .i_set_fifo_delay(i_set_fifo_delay),
    .i_common_counter(i_common_counter), .o_valid(o_valid), .o_data(o_data),
    .o_lane_counter(o_lane_counter), .o_delay(o_delay), .o_delay_valid(o_delay_valid),
    .o_dbg_state(o_dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 counting, 2 holding, 3 locked
  int                 m_phase, m_cnt, m_delay;
  bit                 m_valid, m_known;
  logic [NB_DATA-1:0] m_data;
  logic [NB_DATA-1:0] hist[$];

  task automatic model_step();
    int old_d, diff, idx;
    if (i_reset || i_resync) begin
      m_phase = 0; m_cnt = 0; m_delay = 0; m_valid = 0; m_data = '0; m_known = 1;
      hist.delete();
    end else begin
      old_d = m_delay;
      if (i_enable) begin
        diff = (int'(i_common_counter) >= m_cnt) ? int'(i_common_counter) - m_cnt : 0;
        if (diff > MAX_SKEW - 1) diff = MAX_SKEW - 1;
        if (m_phase == 0) begin
          m_cnt = 0;
          if (i_enable_counter) begin
            m_phase = 1;
            m_cnt = i_stop_counter ? 0 : 1;
          end
        end else if (m_phase == 1 || m_phase == 2) begin
          if (i_set_fifo_delay) begin
            m_phase = 3; m_delay = diff;
          end else if (m_phase == 1 && i_stop_counter) begin
            m_phase = 2;
          end else if (!i_enable_counter) begin
            m_phase = 0; m_cnt = 0;
          end else if (m_phase == 1 && m_cnt < MAX_SKEW) begin
            m_cnt = m_cnt + 1;
          end
        end
      end
      m_valid = i_valid;
      if (i_valid) begin
        hist.push_back(i_data);
        if (hist.size() > 64) void'(hist.pop_front());
        idx = hist.size() - 1 - old_d;
        if (idx >= 0) begin
          m_data = hist[idx]; m_known = 1;
        end else begin
          m_known = 0;
        end
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [NB_DATA-1:0] act,
                     input logic [NB_DATA-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("valid", NB_DATA'(o_valid), NB_DATA'(m_valid));
    chk("lane_counter", NB_DATA'(o_lane_counter), NB_DATA'(m_cnt));
    chk("delay", NB_DATA'(o_delay), NB_DATA'(m_delay));
    chk("delay_valid", NB_DATA'(o_delay_valid), NB_DATA'(m_phase == 3));
    if (m_known) chk("data", o_data, m_data);
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic ctl(input bit en_cnt, input bit stop, input bit set,
                     input logic [NB_COUNT-1:0] common);
    i_enable_counter = en_cnt;
    i_stop_counter   = stop;
    i_set_fifo_delay = set;
    i_common_counter = common;
  endtask

  task automatic do_reset();
    i_reset = 1'b1; ctl(0, 0, 0, '0);
    tick();
    i_reset = 1'b0;
  endtask

  typedef struct {
    bit                  rst;
    bit                  en_cnt;
    bit                  stop;
    bit                  set;
    logic [NB_COUNT-1:0] common;
    int                  exp_cnt;
    int                  exp_delay;
    bit                  exp_dv;
  } vec_t;

  vec_t vecs[10];
  int   v;

  initial begin
    i_reset = 1'b1; i_enable = 1'b1; i_resync = 1'b0; i_valid = 1'b0; i_data = '0;
    ctl(0, 0, 0, '0);
    #1;

    // Test 1: transparent path after reset, latency 1.
    do_reset();
    chk("rst_valid", NB_DATA'(o_valid), '0);
    chk("rst_data", o_data, '0);
    for (int n = 0; n < 10; n++) begin
      i_valid = 1'b1; i_data = NB_DATA'(n);
      tick();
      chk("t1_data", o_data, NB_DATA'(n));
    end
    i_valid = 1'b0;
    tick();
    chk("t1_idle_valid", NB_DATA'(o_valid), '0);
    chk("t1_hold_data", o_data, NB_DATA'(9));

    // Test 2: vector table, count 5, hold, lock with common 9 -> delay 4.
    vecs[0] = '{1, 0, 0, 0, 5'd0, 0, 0, 0};
    vecs[1] = '{0, 1, 0, 0, 5'd1, 1, 0, 0};
    vecs[2] = '{0, 1, 0, 0, 5'd2, 2, 0, 0};
    vecs[3] = '{0, 1, 0, 0, 5'd3, 3, 0, 0};
    vecs[4] = '{0, 1, 0, 0, 5'd4, 4, 0, 0};
    vecs[5] = '{0, 1, 0, 0, 5'd5, 5, 0, 0};
    vecs[6] = '{0, 1, 1, 0, 5'd5, 5, 0, 0};
    vecs[7] = '{0, 1, 1, 0, 5'd7, 5, 0, 0};
    vecs[8] = '{0, 1, 1, 1, 5'd9, 5, 4, 1};
    vecs[9] = '{0, 0, 0, 0, 5'd9, 5, 4, 1};
    v = 100;
    for (int r = 0; r < 10; r++) begin
      i_reset = vecs[r].rst;
      ctl(vecs[r].en_cnt, vecs[r].stop, vecs[r].set, vecs[r].common);
      i_valid = 1'b1; i_data = NB_DATA'(v); v++;
      tick();
      chk("tbl_counter", NB_DATA'(o_lane_counter), NB_DATA'(vecs[r].exp_cnt));
      chk("tbl_delay", NB_DATA'(o_delay), NB_DATA'(vecs[r].exp_delay));
      chk("tbl_delay_valid", NB_DATA'(o_delay_valid), NB_DATA'(vecs[r].exp_dv));
    end
    i_reset = 1'b0; ctl(0, 0, 0, '0);
    for (int n = 0; n < 12; n++) begin
      i_data = NB_DATA'(v);
      tick();
      chk("t2_delayed_data", o_data, NB_DATA'(v - 4));
      v++;
    end

    // Test 3: stop and set in the same cycle with counter 7, common 7.
    do_reset();
    ctl(1, 0, 0, '0);
    for (int n = 0; n < 7; n++) begin i_data = NB_DATA'(200 + n); tick(); end
    chk("t3_counter7", NB_DATA'(o_lane_counter), NB_DATA'(7));
    ctl(1, 1, 1, 5'd7); i_data = NB_DATA'(300);
    tick();
    chk("t3_delay0", NB_DATA'(o_delay), '0);
    chk("t3_locked", NB_DATA'(o_delay_valid), NB_DATA'(1));
    ctl(1, 0, 0, 5'd7); i_data = NB_DATA'(301);
    tick();
    chk("t3_counter_frozen", NB_DATA'(o_lane_counter), NB_DATA'(7));
    chk("t3_transparent", o_data, NB_DATA'(301));

    // Test 4: counter saturates at 16; common 3 below it gives delay 0.
    do_reset();
    ctl(1, 0, 0, '0);
    for (int n = 0; n < 20; n++) begin i_data = NB_DATA'(n); tick(); end
    chk("t4_saturated", NB_DATA'(o_lane_counter), NB_DATA'(16));
    ctl(1, 0, 1, 5'd3);
    tick();
    chk("t4_delay0", NB_DATA'(o_delay), '0);
    chk("t4_locked", NB_DATA'(o_delay_valid), NB_DATA'(1));

    // Test 5: abort from HOLD, then set while idle is ignored.
    do_reset();
    ctl(1, 0, 0, '0);
    for (int n = 0; n < 3; n++) tick();
    ctl(1, 1, 0, '0);
    tick();
    chk("t5_hold3", NB_DATA'(o_lane_counter), NB_DATA'(3));
    ctl(0, 0, 0, '0);
    tick();
    chk("t5_abort_counter", NB_DATA'(o_lane_counter), '0);
    chk("t5_abort_dv", NB_DATA'(o_delay_valid), '0);
    ctl(0, 0, 1, 5'd9);
    tick();
    chk("t5_idle_set_ignored", NB_DATA'(o_delay_valid), '0);
    chk("t5_idle_delay", NB_DATA'(o_delay), '0);

    // Test 6: delay clamped to 15, stream across pointer wrap, resync mid-stream.
    do_reset();
    v = 0;
    i_valid = 1'b1;
    ctl(1, 0, 0, '0);
    for (int n = 0; n < 2; n++) begin i_data = NB_DATA'(v); v++; tick(); end
    ctl(1, 1, 1, 5'd31); i_data = NB_DATA'(v); v++;
    tick();
    chk("t6_delay_clamp", NB_DATA'(o_delay), NB_DATA'(15));
    ctl(0, 0, 0, '0);
    for (int n = 0; n < 40; n++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_data = NB_DATA'(v);
      tick();
      if (i_valid) begin
        if (v >= 15) chk("t6_wrap_data", o_data, NB_DATA'(v - 15));
        v++;
      end
    end
    i_resync = 1'b1; i_valid = 1'b1; i_data = NB_DATA'(v);
    tick();
    chk("t6_resync_delay", NB_DATA'(o_delay), '0);
    chk("t6_resync_dv", NB_DATA'(o_delay_valid), '0);
    chk("t6_resync_counter", NB_DATA'(o_lane_counter), '0);
    i_resync = 1'b0;
    for (int n = 0; n < 4; n++) begin
      i_data = NB_DATA'(500 + n);
      tick();
      chk("t6_transparent", o_data, NB_DATA'(500 + n));
    end

    // Random run against the model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      i_reset  = ($urandom_range(0, 149) == 0);
      i_resync = ($urandom_range(0, 149) == 0);
      i_enable = ($urandom_range(0, 9) != 0);
      ctl($urandom_range(0, 7) != 0, $urandom_range(0, 11) == 0,
          $urandom_range(0, 15) == 0, NB_COUNT'($urandom_range(0, 31)));
      i_valid = ($urandom_range(0, 3) != 0);
      i_data  = NB_DATA'({$urandom(), $urandom(), $urandom()});
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
